// File: rtl/alu_pkg.sv
// Shared types and helpers for the multi-precision sequential ALU.
// Opcode and state enums plus word-index and carry-in helper functions.
package alu_pkg;

    typedef enum logic [3:0] {
        PASSTHROUGH     = 4'd0,
        ADD             = 4'd1,
        ADD_WITH_CIN    = 4'd2,
        SUBTRACT        = 4'd3,
        SUB_WITH_CIN    = 4'd4,
        TWOS_COMPLEMENT = 4'd5,
        INCREMENT       = 4'd6,
        DECREMENT       = 4'd7,
        BIT_AND         = 4'd8,
        BIT_OR          = 4'd9,
        BIT_XOR         = 4'd10,
        BIT_NOT         = 4'd11,
        SHIFT_LEFT      = 4'd12,
        ASR             = 4'd13,
        LSR             = 4'd14,
        ROTATE          = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int idx_w(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

    // Carry fed into word 0; subtract-style ops get +1 to complete the two's complement.
    function automatic logic first_cin(input opcode_t op, input logic cin);
        case (op)
            ADD_WITH_CIN, SUB_WITH_CIN:            return cin;
            SUBTRACT, TWOS_COMPLEMENT, INCREMENT:  return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic is_arith(input opcode_t op);
        return op inside {ADD, ADD_WITH_CIN, SUBTRACT, SUB_WITH_CIN,
                          TWOS_COMPLEMENT, INCREMENT, DECREMENT};
    endfunction

    function automatic logic is_unsupported(input opcode_t op);
        return op inside {ASR, LSR, ROTATE};
    endfunction

endpackage

// File: rtl/alu_slice.sv
// One WIDTH-bit combinational slice: arithmetic via a shared adder, logic ops and shift-left.
// The overflow output is meaningful for arithmetic ops only and is gated by the caller.
module alu_slice
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  opcode_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH:0]   sum;

    // Every arithmetic op is expressed as add_x + add_y + cin.
    always_comb begin
        add_x = a;
        add_y = '0;
        case (op)
            ADD, ADD_WITH_CIN:         add_y = b;
            SUBTRACT, SUB_WITH_CIN:    add_y = ~b;
            TWOS_COMPLEMENT:           add_x = ~a;
            DECREMENT:                 add_y = '1;
            default:                   add_y = '0;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        y    = a;
        cout = 1'b0;
        ovf  = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
        case (op)
            ADD, ADD_WITH_CIN, SUBTRACT, SUB_WITH_CIN,
            TWOS_COMPLEMENT, INCREMENT, DECREMENT: begin
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
            end
            BIT_AND:    y = a & b;
            BIT_OR:     y = a | b;
            BIT_XOR:    y = a ^ b;
            BIT_NOT:    y = ~a;
            SHIFT_LEFT: begin
                y    = {a[WIDTH-2:0], cin};
                cout = a[WIDTH-1];
            end
            default:    y = a;
        endcase
    end

endmodule

// File: rtl/mp_alu_seq.sv
// Multi-precision ALU that walks WORDS slices LSW-first through one alu_slice, one per cycle.
// Define MP_ALU_SEQ_ERR_EN to add rsp_err and flag ASR/LSR/ROTATE as errors instead of passthrough.
module mp_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  opcode_t                cmd_op,
    input  logic [WIDTH*WORDS-1:0] cmd_a,
    input  logic [WIDTH*WORDS-1:0] cmd_b,
    input  logic                   cmd_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH*WORDS-1:0] rsp_data,
    output logic                   rsp_carry,
    output logic                   rsp_zero,
    output logic                   rsp_negative,
    output logic                   rsp_overflow,
    output logic                   rsp_parity,
`ifdef MP_ALU_SEQ_ERR_EN
    output logic                   rsp_err,
`endif
    output state_t                 dbg_state
);

    localparam int N  = WIDTH * WORDS;
    localparam int IW = idx_w(WORDS);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // cmd_ready is high only in IDLE and rsp_valid only in DONE, so the two never overlap.
    state_t           state;
    logic [IW-1:0]    idx;
    opcode_t          op_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic             c_q;
    logic [WIDTH-1:0] s_y;
    logic             s_cout;
    logic             s_ovf;
    logic [N-1:0]     res_next;
    logic             err_case;

    alu_slice #(.WIDTH(WIDTH)) u_slice (
        .op   (op_q),
        .a    (a_q[WIDTH-1:0]),
        .b    (b_q[WIDTH-1:0]),
        .cin  (c_q),
        .y    (s_y),
        .cout (s_cout),
        .ovf  (s_ovf)
    );

    // Result words shift in from the top so word 0 ends up at the bottom after WORDS steps.
    assign res_next = {s_y, rsp_data[N-1:WIDTH]};

`ifdef MP_ALU_SEQ_ERR_EN
    assign err_case = is_unsupported(op_q);
`else
    assign err_case = 1'b0;
`endif

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            op_q         <= PASSTHROUGH;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= 1'b0;
            rsp_data     <= '0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_parity   <= 1'b0;
`ifdef MP_ALU_SEQ_ERR_EN
            rsp_err      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        a_q   <= cmd_a;
                        b_q   <= cmd_b;
                        c_q   <= first_cin(cmd_op, cmd_cin);
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q      <= {{WIDTH{1'b0}}, a_q[N-1:WIDTH]};
                    b_q      <= {{WIDTH{1'b0}}, b_q[N-1:WIDTH]};
                    c_q      <= s_cout;
                    rsp_data <= res_next;
                    idx      <= idx + 1'b1;
                    if (idx == IW'(WORDS - 1)) begin
                        state        <= S_DONE;
                        rsp_carry    <= s_cout & ~err_case;
                        rsp_zero     <= (res_next == '0) & ~err_case;
                        rsp_negative <= res_next[N-1] & ~err_case;
                        rsp_overflow <= s_ovf & is_arith(op_q) & ~err_case;
                        rsp_parity   <= (^res_next) & ~err_case;
                        if (err_case) rsp_data <= '0;
`ifdef MP_ALU_SEQ_ERR_EN
                        rsp_err      <= err_case;
`endif
                    end
                end
                S_DONE: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_alu_seq.sv
// Directed, table-driven bench for mp_alu_seq at WIDTH=8, WORDS=4 (32-bit operands).
// Flags are compared packed as {carry, zero, negative, overflow, parity}.
module tb_mp_alu_seq;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    opcode_t     cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_cin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        rsp_negative;
    logic        rsp_overflow;
    logic        rsp_parity;
`ifdef MP_ALU_SEQ_ERR_EN
    logic        rsp_err;
`endif
    state_t      dbg_state;

    int errs;
    int checks;

    typedef struct {
        opcode_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] data;
        logic [4:0]  flags;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];
    logic [31:0] exp_q[$];

    mp_alu_seq #(.WIDTH(8), .WORDS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_cin      (cmd_cin),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_carry    (rsp_carry),
        .rsp_zero     (rsp_zero),
        .rsp_negative (rsp_negative),
        .rsp_overflow (rsp_overflow),
        .rsp_parity   (rsp_parity),
`ifdef MP_ALU_SEQ_ERR_EN
        .rsp_err      (rsp_err),
`endif
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [4:0] flags_now();
        return {rsp_carry, rsp_zero, rsp_negative, rsp_overflow, rsp_parity};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Drive one command, measure latency, check result, optionally stall rsp_ready for hold cycles.
    task automatic run_vec(input string name, input vec_t v, input int hold);
        int guard;
        int lat;
        @(negedge clk);
        cmd_op    = v.op;
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_cin   = v.cin;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check({name, "_accept_timeout"}, 64'(guard), 64'd0);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a     = $urandom();
        cmd_b     = $urandom();
        cmd_op    = BIT_NOT;
        cmd_cin   = ~v.cin;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd4);
        check({name, "_data"}, 64'(rsp_data), 64'(v.data));
        check({name, "_flags"}, 64'(flags_now()), 64'(v.flags));
`ifdef MP_ALU_SEQ_ERR_EN
        check({name, "_err"}, 64'(rsp_err), 64'(is_unsupported(v.op)));
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({name, "_hold"}, {25'd0, rsp_valid, cmd_ready, rsp_data, flags_now()},
                  {25'd0, 1'b1, 1'b0, v.data, v.flags});
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({name, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        vec_t sh;
        vec_t bb[3];
        int   seen;
        int   cyc;
        int   n_acc;
        int   n_rsp;
        int   last_acc;
        logic [31:0] e;

        errs = 0;
        checks = 0;
        vecs[0]  = '{ADD,             32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 5'b11000};
        vecs[1]  = '{SUBTRACT,        32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 5'b10011};
        vecs[2]  = '{ADD,             32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 5'b00111};
        vecs[3]  = '{ADD,             32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 5'b00001};
        vecs[4]  = '{ADD_WITH_CIN,    32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 5'b00001};
        vecs[5]  = '{SUB_WITH_CIN,    32'h00000005, 32'h00000003, 1'b0, 32'h00000001, 5'b10001};
        vecs[6]  = '{SUBTRACT,        32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 5'b00100};
        vecs[7]  = '{TWOS_COMPLEMENT, 32'h00000001, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 5'b00100};
        vecs[8]  = '{TWOS_COMPLEMENT, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 5'b11000};
        vecs[9]  = '{TWOS_COMPLEMENT, 32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 5'b00111};
        vecs[10] = '{INCREMENT,       32'h000000FF, 32'hFFFFFFFF, 1'b0, 32'h00000100, 5'b00001};
        vecs[11] = '{DECREMENT,       32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 5'b00100};
        vecs[12] = '{DECREMENT,       32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 5'b11000};
        vecs[13] = '{BIT_AND,         32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 5'b00100};
        vecs[14] = '{BIT_OR,          32'h0F0F0000, 32'h000000F1, 1'b0, 32'h0F0F00F1, 5'b00001};
        vecs[15] = '{BIT_XOR,         32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 5'b00100};
        vecs[16] = '{BIT_NOT,         32'h00000000, 32'h12345678, 1'b1, 32'hFFFFFFFF, 5'b00100};
        vecs[17] = '{PASSTHROUGH,     32'h12345678, 32'hFFFFFFFF, 1'b1, 32'h12345678, 5'b00001};
`ifdef MP_ALU_SEQ_ERR_EN
        vecs[18] = '{LSR,             32'h12345678, 32'h00000000, 1'b0, 32'h00000000, 5'b00000};
`else
        vecs[18] = '{LSR,             32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 5'b00001};
`endif
        vecs[19] = '{SUB_WITH_CIN,    32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 5'b11000};

        // Reset state
        cmd_valid = 1'b0;
        cmd_op    = PASSTHROUGH;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_cin   = 1'b0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        #3;
        check("reset_state", {27'd0, cmd_ready, rsp_valid, rsp_data, flags_now()},
              {27'd0, 1'b1, 1'b0, 32'd0, 5'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], 0);
        end

        // Shift-left with a stalled consumer
        sh = '{SHIFT_LEFT, 32'h80808080, 32'h00000000, 1'b1, 32'h01010100, 5'b10001};
        run_vec("shl_hold", sh, 5);

        // Reset two cycles into RUN discards the operation
        @(negedge clk);
        cmd_op = ADD; cmd_a = 32'd1; cmd_b = 32'd1; cmd_cin = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("rst_run_entered", 64'(dbg_state), 64'(S_RUN));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_run_outputs", {27'd0, cmd_ready, rsp_valid, rsp_data, flags_now()},
              {27'd0, 1'b1, 1'b0, 32'd0, 5'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check("rst_no_response", 64'(seen), 64'd0);
        run_vec("after_rst_add", '{ADD, 32'd2, 32'd3, 1'b0, 32'd5, 5'b00000}, 0);

        // Back-to-back commands with the consumer always ready
        bb[0] = '{ADD,      32'd10,        32'd20,        1'b0, 32'd30,        5'b0};
        bb[1] = '{SUBTRACT, 32'd100,       32'd1,         1'b0, 32'd99,        5'b0};
        bb[2] = '{BIT_XOR,  32'hFF00FF00,  32'h0F0F0F0F,  1'b0, 32'hF00FF00F,  5'b0};
        exp_q.delete();
        cyc = 0; n_acc = 0; n_rsp = 0; last_acc = 0;
        @(negedge clk);
        cmd_op = bb[0].op; cmd_a = bb[0].a; cmd_b = bb[0].b; cmd_cin = bb[0].cin;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        while (n_rsp < 3 && cyc < 60) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_rsp", 64'(rsp_data), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("b2b_data%0d", n_rsp), 64'(rsp_data), 64'(e));
                end
                n_rsp++;
            end
            if (cmd_ready && cmd_valid) begin
                exp_q.push_back(bb[n_acc].data);
                if (n_acc > 0) check($sformatf("b2b_period%0d", n_acc), 64'(cyc - last_acc), 64'd6);
                last_acc = cyc;
                n_acc++;
                @(posedge clk);
                #1;
                if (n_acc < 3) begin
                    cmd_op = bb[n_acc].op; cmd_a = bb[n_acc].a;
                    cmd_b = bb[n_acc].b; cmd_cin = bb[n_acc].cin;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        check("b2b_responses", 64'(n_rsp), 64'd3);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
